// File: rtl/s2_pool_ctrl_pkg.sv
// Shared types and default geometry for the S2 average-pooling sequencer.
// Holds the FP16 word type, the sequencer state enum and derived map sizes.
package pool_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_A,
    RD_B,
    RD_C,
    RD_D,
    CAP,
    WR,
    DONE
  } pool_state_e;

  localparam int DEF_IN_W = 28;
  localparam int DEF_IN_H = 28;

  localparam int OUT_W     = DEF_IN_W / 2;
  localparam int OUT_H     = DEF_IN_H / 2;
  localparam int IN_PLANE  = DEF_IN_W * DEF_IN_H;
  localparam int OUT_PLANE = OUT_W * OUT_H;

  function automatic int cntW(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/s2_pool_ctrl_if.sv
// Bus bundle between the S2 sequencer and its environment.
// master: sequencer side (start/read data/pool result in); slave: environment side.
interface s2_pool_ctrl_if #(
  parameter int DW  = 16,
  parameter int RAW = 13,
  parameter int WAW = 11
);

  logic           start;
  logic           busy;
  logic           done;
  logic           rd_en;
  logic [RAW-1:0] rd_addr;
  logic [DW-1:0]  rd_data;
  logic [DW-1:0]  pool_a;
  logic [DW-1:0]  pool_b;
  logic [DW-1:0]  pool_c;
  logic [DW-1:0]  pool_d;
  logic [DW-1:0]  pool_result;
  logic           wr_en;
  logic [WAW-1:0] wr_addr;
  logic [DW-1:0]  wr_data;

  modport master (
    input  start, rd_data, pool_result,
    output busy, done, rd_en, rd_addr,
    output pool_a, pool_b, pool_c, pool_d,
    output wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data, pool_result,
    input  busy, done, rd_en, rd_addr,
    input  pool_a, pool_b, pool_c, pool_d,
    input  wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/s2_pool_ctrl_addr_gen.sv
// Window address generator: col/row/channel counters with incremental bases.
// Ports: clear/step in; addrA..addrD, wrAddr, lastWin out.
module pool_addr_gen
  import pool_pkg::*;
#(
  parameter int IN_W = 28,
  parameter int IN_H = 28,
  parameter int CH   = 6,
  parameter int RAW  = 13,
  parameter int WAW  = 11
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           step,
  output logic [RAW-1:0] addrA,
  output logic [RAW-1:0] addrB,
  output logic [RAW-1:0] addrC,
  output logic [RAW-1:0] addrD,
  output logic [WAW-1:0] wrAddr,
  output logic           lastWin
);

  localparam int HALF_W = IN_W / 2;
  localparam int HALF_H = IN_H / 2;
  localparam int CW = cntW(HALF_W);
  localparam int RW = cntW(HALF_H);
  localparam int HW = cntW(CH);

  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic [HW-1:0]  chn;
  logic [RAW-1:0] chBase;
  logic [RAW-1:0] rowOff;
  logic [RAW-1:0] colOff;
  logic [WAW-1:0] outIdx;
  logic           lastCol;
  logic           lastRow;
  logic           lastCh;

  assign lastCol = (col == CW'(HALF_W - 1));
  assign lastRow = (row == RW'(HALF_H - 1));
  assign lastCh  = (chn == HW'(CH - 1));
  assign lastWin = lastCol && lastRow && lastCh;

  // Top-left word of the window; the other three are fixed offsets.
  assign addrA  = chBase + rowOff + colOff;
  assign addrB  = addrA + RAW'(1);
  assign addrC  = addrA + RAW'(IN_W);
  assign addrD  = addrA + RAW'(IN_W + 1);
  assign wrAddr = outIdx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col    <= '0;
      row    <= '0;
      chn    <= '0;
      chBase <= '0;
      rowOff <= '0;
      colOff <= '0;
      outIdx <= '0;
    end else if (clear) begin
      col    <= '0;
      row    <= '0;
      chn    <= '0;
      chBase <= '0;
      rowOff <= '0;
      colOff <= '0;
      outIdx <= '0;
    end else if (step) begin
      outIdx <= outIdx + WAW'(1);
      if (!lastCol) begin
        col    <= col + CW'(1);
        colOff <= colOff + RAW'(2);
      end else begin
        col    <= '0;
        colOff <= '0;
        if (!lastRow) begin
          row    <= row + RW'(1);
          rowOff <= rowOff + RAW'(2 * IN_W);
        end else begin
          row    <= '0;
          rowOff <= '0;
          chn    <= chn + HW'(1);
          chBase <= chBase + RAW'(IN_W * IN_H);
        end
      end
    end
  end

endmodule

// File: rtl/s2_pool_ctrl.sv
// S2 average-pooling sequencer: reads 2x2 windows, feeds AvgPoolUnit, writes result.
// Ports: clk, rst_n, bus (start/busy/done, read port, pool operands, write port).
module s2_pool_ctrl
  import pool_pkg::*;
#(
  parameter int IN_W = 28,
  parameter int IN_H = 28,
  parameter int CH   = 6,
  parameter int DW   = 16,
  parameter int RAW  = 13,
  parameter int WAW  = 11
) (
  input logic            clk,
  input logic            rst_n,
  s2_pool_ctrl_if.master bus
);

  pool_state_e    state;
  logic           armed;
  logic           lastQ;
  logic           busyQ;
  logic           doneQ;
  logic           rdEnQ;
  logic           wrEnQ;
  logic [RAW-1:0] rdAddrQ;
  logic [WAW-1:0] wrAddrQ;
  logic [DW-1:0]  opA;
  logic [DW-1:0]  opB;
  logic [DW-1:0]  opC;
  logic [DW-1:0]  opD;
  logic [RAW-1:0] addrA;
  logic [RAW-1:0] addrB;
  logic [RAW-1:0] addrC;
  logic [RAW-1:0] addrD;
  logic [WAW-1:0] winIdx;
  logic           lastWin;
  logic           clear;
  logic           step;

  assign clear = (state == IDLE) && bus.start && armed;
  // Counters move on during CAP so the next window's A is ready at WR.
  assign step  = (state == CAP) && !lastWin;

  pool_addr_gen #(
    .IN_W(IN_W),
    .IN_H(IN_H),
    .CH  (CH),
    .RAW (RAW),
    .WAW (WAW)
  ) u_addr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (clear),
    .step   (step),
    .addrA  (addrA),
    .addrB  (addrB),
    .addrC  (addrC),
    .addrD  (addrD),
    .wrAddr (winIdx),
    .lastWin(lastWin)
  );

  // Blocks a start that arrives on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      lastQ   <= 1'b0;
      busyQ   <= 1'b0;
      doneQ   <= 1'b0;
      rdEnQ   <= 1'b0;
      wrEnQ   <= 1'b0;
      rdAddrQ <= '0;
      wrAddrQ <= '0;
      opA     <= '0;
      opB     <= '0;
      opC     <= '0;
      opD     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (clear) begin
            state   <= RD_A;
            busyQ   <= 1'b1;
            rdEnQ   <= 1'b1;
            rdAddrQ <= '0;
          end
        end
        RD_A: begin
          state   <= RD_B;
          rdAddrQ <= addrB;
        end
        RD_B: begin
          state   <= RD_C;
          rdAddrQ <= addrC;
          opA     <= bus.rd_data;
        end
        RD_C: begin
          state   <= RD_D;
          rdAddrQ <= addrD;
          opB     <= bus.rd_data;
        end
        RD_D: begin
          state   <= CAP;
          rdEnQ   <= 1'b0;
          rdAddrQ <= '0;
          opC     <= bus.rd_data;
        end
        CAP: begin
          state   <= WR;
          opD     <= bus.rd_data;
          wrEnQ   <= 1'b1;
          wrAddrQ <= winIdx;
          lastQ   <= lastWin;
        end
        WR: begin
          wrEnQ   <= 1'b0;
          wrAddrQ <= '0;
          if (lastQ) begin
            state <= DONE;
            busyQ <= 1'b0;
            doneQ <= 1'b1;
          end else begin
            state   <= RD_A;
            rdEnQ   <= 1'b1;
            rdAddrQ <= addrA;
          end
        end
        DONE: begin
          state <= IDLE;
          doneQ <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busyQ;
  assign bus.done    = doneQ;
  assign bus.rd_en   = rdEnQ;
  assign bus.rd_addr = rdAddrQ;
  assign bus.pool_a  = opA;
  assign bus.pool_b  = opB;
  assign bus.pool_c  = opC;
  assign bus.pool_d  = opD;
  assign bus.wr_en   = wrEnQ;
  assign bus.wr_addr = wrAddrQ;
  assign bus.wr_data = wrEnQ ? bus.pool_result : '0;

endmodule
